// File: rtl/ppu_pkg.sv
// Shared PPU OAM types: DMA sequencer states, grant selects and OAM geometry.
// The ALIGN state exists only when PPU_OAM_DMA_ODD_ALIGN_EN is defined.
package ppu_pkg;

  localparam int OAM_DEPTH  = 256;
  localparam int OAM_ADDR_W = 8;

`ifdef PPU_OAM_DMA_ODD_ALIGN_EN
  typedef enum logic [2:0] {
    DMA_IDLE,
    DMA_SETUP,
    DMA_ALIGN,
    DMA_READ,
    DMA_WRITE
  } dma_state_e;
`else
  typedef enum logic [2:0] {
    DMA_IDLE,
    DMA_SETUP,
    DMA_READ,
    DMA_WRITE
  } dma_state_e;
`endif

  typedef enum logic [1:0] {
    GNT_EVAL,
    GNT_CPU,
    GNT_DMA,
    GNT_IDLE
  } gnt_sel_e;

endpackage

// File: rtl/ppu_oam_arbiter_if.sv
// Signal bundle around the OAM arbiter: sprite-load FSM, CPU register strobes,
// CPU-bus DMA reads and the single-port OAM RAM. slave = arbiter, master = surroundings.
interface ppu_oam_arbiter_if;
  import ppu_pkg::*;

  logic                  eval_busy;
  logic [OAM_ADDR_W-1:0] eval_addr;
  logic [OAM_ADDR_W-1:0] oam_base_addr;
  logic                  cpu_oamaddr_wr;
  logic                  cpu_oamdata_wr;
  logic [7:0]            cpu_wdata;
  logic [7:0]            cpu_rdata;
  logic                  dma_start;
  logic [7:0]            dma_page;
  logic [15:0]           dma_mem_addr;
  logic                  dma_mem_rd;
  logic [7:0]            dma_mem_data;
  logic                  dma_busy;
  logic                  cpu_stall;
  logic [OAM_ADDR_W-1:0] oam_addr;
  logic                  oam_we;
  logic [7:0]            oam_wdata;
  logic [7:0]            oam_rdata;
  logic                  wr_overrun;

  modport slave (
    input  eval_busy, eval_addr, cpu_oamaddr_wr, cpu_oamdata_wr, cpu_wdata,
           dma_start, dma_page, dma_mem_data, oam_rdata,
    output oam_base_addr, cpu_rdata, dma_mem_addr, dma_mem_rd, dma_busy,
           cpu_stall, oam_addr, oam_we, oam_wdata, wr_overrun
  );

  modport master (
    output eval_busy, eval_addr, cpu_oamaddr_wr, cpu_oamdata_wr, cpu_wdata,
           dma_start, dma_page, dma_mem_data, oam_rdata,
    input  oam_base_addr, cpu_rdata, dma_mem_addr, dma_mem_rd, dma_busy,
           cpu_stall, oam_addr, oam_we, oam_wdata, wr_overrun
  );

endinterface

// File: rtl/ppu_oam_dma_seq.sv
// $4014 OAM DMA sequencer: reads a CPU page byte by byte and requests OAM writes.
// PPU_OAM_DMA_ODD_ALIGN_EN adds a cycle-parity register and one ALIGN cycle on odd starts.
module ppu_oam_dma_seq
  import ppu_pkg::*;
#(
  parameter int DMA_LEN = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [7:0]            page,
  input  logic [OAM_ADDR_W-1:0] base,
  input  logic                  grant,
  input  logic [7:0]            mem_data,
  output logic                  busy,
  output logic [15:0]           mem_addr,
  output logic                  mem_rd,
  output logic                  req,
  output logic [OAM_ADDR_W-1:0] waddr,
  output logic [7:0]            wdata
);

  localparam logic [OAM_ADDR_W-1:0] LAST_IDX = OAM_ADDR_W'(DMA_LEN - 1);

  dma_state_e            state;
  logic [OAM_ADDR_W-1:0] idx;
  logic [7:0]            page_q;
  logic                  first_p0;
  logic [7:0]            data_hold_p1;

`ifdef PPU_OAM_DMA_ODD_ALIGN_EN
  logic parity;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) parity <= 1'b0;
    else      parity <= ~parity;
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= DMA_IDLE;
      busy     <= 1'b0;
      mem_rd   <= 1'b0;
      mem_addr <= '0;
      idx      <= '0;
      page_q   <= '0;
      first_p0 <= 1'b0;
    end else begin
      case (state)
        DMA_IDLE: begin
          if (start) begin
            state  <= DMA_SETUP;
            busy   <= 1'b1;
            page_q <= page;
            idx    <= '0;
          end
        end
        DMA_SETUP: begin
`ifdef PPU_OAM_DMA_ODD_ALIGN_EN
          if (parity) begin
            state <= DMA_ALIGN;
          end else begin
            state    <= DMA_READ;
            mem_rd   <= 1'b1;
            mem_addr <= {page_q, idx};
          end
`else
          state    <= DMA_READ;
          mem_rd   <= 1'b1;
          mem_addr <= {page_q, idx};
`endif
        end
`ifdef PPU_OAM_DMA_ODD_ALIGN_EN
        DMA_ALIGN: begin
          state    <= DMA_READ;
          mem_rd   <= 1'b1;
          mem_addr <= {page_q, idx};
        end
`endif
        DMA_READ: begin
          state    <= DMA_WRITE;
          mem_rd   <= 1'b0;
          first_p0 <= 1'b1;
        end
        DMA_WRITE: begin
          first_p0 <= 1'b0;
          if (grant) begin
            idx <= idx + 1'b1;
            if (idx == LAST_IDX) begin
              state <= DMA_IDLE;
              busy  <= 1'b0;
            end else begin
              state    <= DMA_READ;
              mem_rd   <= 1'b1;
              mem_addr <= {page_q, idx + 8'd1};
            end
          end
        end
        default: state <= DMA_IDLE;
      endcase
    end
  end

  // Bus data is only valid in the first WRITE cycle; hold it for blocked cycles.
  always_ff @(posedge clk) begin
    if (first_p0) data_hold_p1 <= mem_data;
  end

  assign req   = (state == DMA_WRITE);
  assign waddr = base + idx;
  assign wdata = first_p0 ? mem_data : data_hold_p1;

endmodule

// File: rtl/ppu_oam_arbiter.sv
// Single-port OAM arbiter: sprite-load FSM > pending CPU write > DMA > idle CPU read.
// Optional PPU_OAM_DMA_ODD_ALIGN_EN enables odd-cycle DMA alignment in the sequencer.
module ppu_oam_arbiter
  import ppu_pkg::*;
#(
  parameter int DMA_LEN = 256
) (
  input  logic               clk,
  input  logic               rst,
  ppu_oam_arbiter_if.slave   bus
);

  gnt_sel_e              gnt;
  logic [OAM_ADDR_W-1:0] oamaddr;
  logic                  pend_vld;
  logic [OAM_ADDR_W-1:0] pend_addr;
  logic [7:0]            pend_data;
  logic                  rd_vld_p0;
  logic                  addr_wr;
  logic                  data_wr;
  logic                  dma_req;
  logic [OAM_ADDR_W-1:0] dma_waddr;
  logic [7:0]            dma_wdata;

  ppu_oam_dma_seq #(
    .DMA_LEN (DMA_LEN)
  ) u_dma_seq (
    .clk      (clk),
    .rst      (rst),
    .start    (bus.dma_start),
    .page     (bus.dma_page),
    .base     (oamaddr),
    .grant    (gnt == GNT_DMA),
    .mem_data (bus.dma_mem_data),
    .busy     (bus.dma_busy),
    .mem_addr (bus.dma_mem_addr),
    .mem_rd   (bus.dma_mem_rd),
    .req      (dma_req),
    .waddr    (dma_waddr),
    .wdata    (dma_wdata)
  );

  // The CPU is stalled during DMA, so any strobe seen then is spurious.
  assign addr_wr = bus.cpu_oamaddr_wr && !bus.dma_busy;
  assign data_wr = bus.cpu_oamdata_wr && !bus.cpu_oamaddr_wr && !bus.dma_busy;

  always_comb begin
    if (bus.eval_busy)  gnt = GNT_EVAL;
    else if (pend_vld)  gnt = GNT_CPU;
    else if (dma_req)   gnt = GNT_DMA;
    else                gnt = GNT_IDLE;
  end

  always_comb begin
    bus.oam_addr  = oamaddr;
    bus.oam_we    = 1'b0;
    bus.oam_wdata = '0;
    case (gnt)
      GNT_EVAL: bus.oam_addr = bus.eval_addr;
      GNT_CPU: begin
        bus.oam_addr  = pend_addr;
        bus.oam_we    = 1'b1;
        bus.oam_wdata = pend_data;
      end
      GNT_DMA: begin
        bus.oam_addr  = dma_waddr;
        bus.oam_we    = 1'b1;
        bus.oam_wdata = dma_wdata;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      oamaddr        <= '0;
      pend_vld       <= 1'b0;
      bus.wr_overrun <= 1'b0;
      rd_vld_p0      <= 1'b0;
      bus.cpu_rdata  <= '0;
    end else begin
      if (addr_wr) begin
        oamaddr        <= bus.cpu_wdata;
        bus.wr_overrun <= 1'b0;
      end else if (data_wr) begin
        if (pend_vld) bus.wr_overrun <= 1'b1;
        else          oamaddr        <= oamaddr + 1'b1;
      end

      if (data_wr && !pend_vld) pend_vld <= 1'b1;
      else if (gnt == GNT_CPU)  pend_vld <= 1'b0;

      // Idle cycles present OAMADDR; the RAM answers one cycle later.
      rd_vld_p0 <= (gnt == GNT_IDLE);
      if (rd_vld_p0) bus.cpu_rdata <= bus.oam_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (data_wr && !pend_vld) begin
      pend_addr <= oamaddr;
      pend_data <= bus.cpu_wdata;
    end
  end

  assign bus.oam_base_addr = oamaddr;
  assign bus.cpu_stall     = bus.dma_busy;

endmodule

// File: tb/tb_ppu_oam_arbiter.sv
// Directed bench for ppu_oam_arbiter with behavioural OAM RAM and CPU-bus models.
// Honours PPU_OAM_DMA_ODD_ALIGN_EN by tracking cycle parity itself.
module tb_ppu_oam_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_chk = 0;
  int   n_err = 0;

  logic [7:0] oam_mem [256];

  ppu_oam_arbiter_if bus ();

  ppu_oam_arbiter #(
    .DMA_LEN (256)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] src_byte(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  // OAM RAM: one-cycle read latency.
  always @(posedge clk) begin
    if (bus.oam_we) oam_mem[bus.oam_addr] <= bus.oam_wdata;
    bus.oam_rdata <= oam_mem[bus.oam_addr];
  end

  // CPU bus: data valid only in the cycle after the read strobe.
  always @(posedge clk) begin
    if (bus.dma_mem_rd) bus.dma_mem_data <= src_byte(bus.dma_mem_addr);
    else                bus.dma_mem_data <= 8'hEE;
  end

`ifdef PPU_OAM_DMA_ODD_ALIGN_EN
  logic tb_par;
  always @(posedge clk or negedge rst) begin
    if (!rst) tb_par <= 1'b0;
    else      tb_par <= ~tb_par;
  end
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_oamaddr(input logic [7:0] v);
    bus.cpu_oamaddr_wr = 1'b1;
    bus.cpu_wdata      = v;
    tick();
    bus.cpu_oamaddr_wr = 1'b0;
  endtask

  // Busy timeline: cycle 1 SETUP, READ k at 2+2k, WRITE k at 3+2k (shifted by 1 if aligned).
  task automatic run_dma(input logic [7:0] page, input int eval_at, input int abort_at,
                         input bit poke);
    int         busy_cnt, rd_cnt, addr_err, cont_err, cyc, exp_len, blocked;
    bit         done, align;
    logic [7:0] base0, a;
    busy_cnt = 0; rd_cnt = 0; addr_err = 0; cont_err = 0; done = 0; align = 0;
    base0 = bus.oam_base_addr;
    bus.dma_page  = page;
    bus.dma_start = 1'b1;
    tick();
    bus.dma_start = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      cyc = busy_cnt + 1;
      bus.eval_busy = (eval_at > 0) && (cyc >= eval_at) && (cyc < eval_at + 20);
      bus.eval_addr = 8'h33;
      if (poke) begin
        bus.dma_start      = (cyc == 50);
        bus.dma_page       = (cyc >= 50) ? 8'h07 : page;
        bus.cpu_oamdata_wr = (cyc == 60);
        bus.cpu_wdata      = 8'h99;
      end
      if (cyc == abort_at) begin
        rst = 1'b0;
        #1;
        chk("abort_busy", bus.dma_busy, 0);
        chk("abort_stall", bus.cpu_stall, 0);
        chk("abort_rd", bus.dma_mem_rd, 0);
        return;
      end
      #1;
      if (!bus.dma_busy) begin
        done = 1;
        break;
      end
      busy_cnt++;
`ifdef PPU_OAM_DMA_ODD_ALIGN_EN
      if (cyc == 1) align = tb_par;
`endif
      if (bus.dma_mem_rd) begin
        if (bus.dma_mem_addr !== {page, rd_cnt[7:0]}) addr_err++;
        rd_cnt++;
      end
      if (eval_at > 0 && cyc == eval_at + 5) begin
        chk("dma_eval_addr", bus.oam_addr, 8'h33);
        chk("dma_eval_we", bus.oam_we, 0);
      end
      tick();
    end
    bus.eval_busy = 1'b0;
    chk("dma_done", done, 1);
    // Eval raised in a READ cycle blocks 19 WRITE cycles; with alignment it lands on WRITE: 20.
    blocked = (eval_at > 0) ? (align ? 20 : 19) : 0;
    exp_len = 513 + int'(align) + blocked;
    chk("dma_busy_len", busy_cnt, exp_len);
    chk("dma_reads", rd_cnt, 256);
    chk("dma_addr_errs", addr_err, 0);
    chk("dma_base_kept", bus.oam_base_addr, base0);
    for (int i = 0; i < 256; i++) begin
      a = base0 + 8'(i);
      if (oam_mem[a] !== src_byte({page, 8'(i)})) cont_err++;
    end
    chk("dma_oam_errs", cont_err, 0);
  endtask

  initial begin
    bus.eval_busy = 0; bus.eval_addr = 0; bus.cpu_oamaddr_wr = 0; bus.cpu_oamdata_wr = 0;
    bus.cpu_wdata = 0; bus.dma_start = 0; bus.dma_page = 0;
    for (int i = 0; i < 256; i++) oam_mem[i] = 8'h00;
    repeat (3) tick();
    chk("rst_base", bus.oam_base_addr, 0);
    chk("rst_busy", bus.dma_busy, 0);
    chk("rst_stall", bus.cpu_stall, 0);
    chk("rst_ovr", bus.wr_overrun, 0);
    chk("rst_we", bus.oam_we, 0);
    chk("rst_rdata", bus.cpu_rdata, 0);
    chk("rst_mrd", bus.dma_mem_rd, 0);
    chk("rst_maddr", bus.dma_mem_addr, 0);
    chk("rst_oaddr", bus.oam_addr, 0);
    rst = 1'b1;
    tick();

    // Plain CPU write retires the cycle after the strobe.
    set_oamaddr(8'h10);
    chk("addr_set", bus.oam_base_addr, 8'h10);
    bus.cpu_oamdata_wr = 1'b1; bus.cpu_wdata = 8'hAB;
    tick();
    bus.cpu_oamdata_wr = 1'b0;
    chk("wr_we", bus.oam_we, 1);
    chk("wr_addr", bus.oam_addr, 8'h10);
    chk("wr_data", bus.oam_wdata, 8'hAB);
    chk("wr_base_inc", bus.oam_base_addr, 8'h11);
    tick();
    chk("wr_we_drop", bus.oam_we, 0);

    // Idle-cycle readback of OAMDATA.
    set_oamaddr(8'h10);
    repeat (3) tick();
    chk("rd_data", bus.cpu_rdata, 8'hAB);

    // Write blocked by sprite evaluation, then an overrun.
    bus.eval_busy = 1'b1; bus.eval_addr = 8'h04;
    bus.cpu_oamdata_wr = 1'b1; bus.cpu_wdata = 8'h55;
    tick();
    chk("ev_addr", bus.oam_addr, 8'h04);
    chk("ev_we", bus.oam_we, 0);
    chk("ev_base", bus.oam_base_addr, 8'h11);
    bus.cpu_wdata = 8'h66;
    tick();
    bus.cpu_oamdata_wr = 1'b0;
    chk("ovr_set", bus.wr_overrun, 1);
    chk("ovr_base", bus.oam_base_addr, 8'h11);
    tick();
    bus.eval_busy = 1'b0;
    #1;
    chk("ev_ret_we", bus.oam_we, 1);
    chk("ev_ret_addr", bus.oam_addr, 8'h10);
    chk("ev_ret_data", bus.oam_wdata, 8'h55);
    tick();
    chk("ev_ret_done", bus.oam_we, 0);

    // Simultaneous address and data strobes: address wins, flag clears.
    bus.cpu_oamaddr_wr = 1'b1; bus.cpu_oamdata_wr = 1'b1; bus.cpu_wdata = 8'h20;
    tick();
    bus.cpu_oamaddr_wr = 1'b0; bus.cpu_oamdata_wr = 1'b0;
    chk("both_base", bus.oam_base_addr, 8'h20);
    chk("both_we", bus.oam_we, 0);
    chk("both_ovr", bus.wr_overrun, 0);

    // DMA with wrap, plus a spurious restart and CPU strobe while busy.
    set_oamaddr(8'hF0);
    run_dma(8'h02, 0, 0, 1'b1);
    bus.dma_start = 1'b0; bus.cpu_oamdata_wr = 1'b0;
    chk("poke_ovr", bus.wr_overrun, 0);
    tick();

    // DMA stretched by 20 cycles of sprite evaluation.
    set_oamaddr(8'h00);
    run_dma(8'h04, 100, 0, 1'b0);
    tick();

    // Reset during byte 100, then a clean full transfer.
    run_dma(8'h05, 0, 202, 1'b0);
    tick();
    chk("abort_base", bus.oam_base_addr, 0);
    rst = 1'b1;
    tick();
    run_dma(8'h06, 0, 0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
